sha256_round_ctrl: RTL and testbench



---
 rtl/sha256_round_ctrl_if.sv | 33 +++
 rtl/sha256_round_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sha256_round_ctrl_if.sv
// Block, K-ROM and digest signals of the SHA-256 round controller.
// SHA224_EN adds the mode224 select that travels with first_blk.
interface sha256_round_ctrl_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         first_blk;
  logic [5:0]   k_addr;
  logic [31:0]  k_value;
  logic         busy;
  logic [255:0] digest;
  logic         digest_valid;
`ifdef SHA224_EN
  logic         mode224;
`endif

  // master is the surrounding system: block feeder, K ROM and digest consumer
  modport master (
`ifdef SHA224_EN
    output mode224,
`endif
    output blk_valid, blk_data, first_blk, k_value,
    input  blk_ready, k_addr, busy, digest, digest_valid
  );

  modport slave (
`ifdef SHA224_EN
    input  mode224,
`endif
    input  blk_valid, blk_data, first_blk, k_value,
    output blk_ready, k_addr, busy, digest, digest_valid
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: one round per cycle, external combinational K ROM.
// Optional macro SHA224_EN adds the SHA-224 IV and truncated digest.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  sha256_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_e;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
`ifdef SHA224_EN
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  round_q;
  logic [31:0] w_q [16];
  logic [31:0] v_q [8];
  logic [31:0] h_q [8];
  logic        dv_q;
`ifdef SHA224_EN
  logic        mode224_q;
`endif

  logic [31:0] iv_w [8];
  logic [31:0] t1_w, t2_w, w_new_w;
  logic        accept_w;

  for (genvar gi = 0; gi < 8; gi++) begin : g_iv
`ifdef SHA224_EN
    assign iv_w[gi] = bus.mode224 ? IV224[gi] : IV256[gi];
`else
    assign iv_w[gi] = IV256[gi];
`endif
  end

  assign accept_w = (state_q == S_IDLE) && bus.blk_valid;

  // v_q[0..7] hold a..h
  assign t1_w = v_q[7] + big_s1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6])
              + bus.k_value + w_q[0];
  assign t2_w = big_s0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
  assign w_new_w = small_s1(w_q[14]) + w_q[9] + small_s0(w_q[1]) + w_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.blk_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.k_addr    = 6'd0;
    case (state_q)
      S_IDLE: begin
        bus.blk_ready = 1'b1;
        if (bus.blk_valid) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        bus.busy   = 1'b1;
        bus.k_addr = round_q;
        if (round_q == LAST_ROUND) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        bus.busy = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= 6'd0;
      dv_q    <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= 32'd0;
        h_q[i] <= IV256[i];
      end
`ifdef SHA224_EN
      mode224_q <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_w) begin
            round_q <= 6'd0;
            for (int i = 0; i < 16; i++) w_q[i] <= bus.blk_data[511 - 32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              v_q[i] <= bus.first_blk ? iv_w[i] : h_q[i];
              if (bus.first_blk) h_q[i] <= iv_w[i];
            end
`ifdef SHA224_EN
            // the mode belongs to the whole message, so chained blocks keep it
            if (bus.first_blk) mode224_q <= bus.mode224;
`endif
          end
        end
        S_ROUND: begin
          v_q[0] <= t1_w + t2_w;
          v_q[1] <= v_q[0];
          v_q[2] <= v_q[1];
          v_q[3] <= v_q[2];
          v_q[4] <= v_q[3] + t1_w;
          v_q[5] <= v_q[4];
          v_q[6] <= v_q[5];
          v_q[7] <= v_q[6];
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_new_w;
          if (round_q != LAST_ROUND) begin
            round_q <= round_q + 6'd1;
          end
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
          dv_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.digest_valid = dv_q;

  always_comb begin
    bus.digest = '0;
    for (int i = 0; i < 8; i++) bus.digest[255 - 32*i -: 32] = h_q[i];
`ifdef SHA224_EN
    if (mode224_q) bus.digest[31:0] = 32'd0;
`endif
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl with a behavioural K ROM.
// Build with +define+SHA224_EN to also exercise the SHA-224 vector.
module tb_sha256_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sha256_round_ctrl_if bus ();

  sha256_round_ctrl #(.ROUNDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  always_comb bus.k_value = K_TAB[bus.k_addr];

  localparam logic [255:0] IV_DIG    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2  = {448'h0, 64'h1c0};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Enters just after a rising edge; returns in the digest_valid cycle (T+66).
  task automatic send_block(input logic [511:0] data, input logic fb);
    int waited;
    waited = 0;
    bus.blk_data  = data;
    bus.first_blk = fb;
    bus.blk_valid = 1'b1;
    while (!bus.blk_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("hs_ready", 256'(bus.blk_ready), 256'd1);
    @(posedge clk); #1;
    // junk offered while busy must be ignored
    bus.blk_data  = ~data;
    bus.first_blk = ~fb;
    for (int r = 0; r < 64; r++) begin
      check("k_addr", 256'(bus.k_addr), 256'(r));
      check("busy_round", 256'({bus.busy, bus.blk_ready, bus.digest_valid}), 256'(3'b100));
      @(posedge clk); #1;
    end
    bus.blk_valid = 1'b0;
    check("k_addr_final", 256'(bus.k_addr), 256'd0);
    check("busy_final", 256'({bus.busy, bus.blk_ready, bus.digest_valid}), 256'(3'b100));
    @(posedge clk); #1;
    check("dv_cycle", 256'({bus.digest_valid, bus.blk_ready, bus.busy}), 256'(3'b110));
    check("k_addr_idle", 256'(bus.k_addr), 256'd0);
  endtask

  initial begin
    int dv_seen;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.first_blk = 1'b0;
`ifdef SHA224_EN
    bus.mode224   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", 256'(bus.blk_ready), 256'd1);
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_dv", 256'(bus.digest_valid), 256'd0);
    check("rst_kaddr", 256'(bus.k_addr), 256'd0);
    check("rst_digest", bus.digest, IV_DIG);

    send_block(ABC_BLK, 1'b1);
    check("abc_digest", bus.digest, ABC_DIG);
    @(posedge clk); #1;
    check("dv_drop", 256'(bus.digest_valid), 256'd0);
    check("digest_hold", bus.digest, ABC_DIG);

    send_block(EMPTY_BLK, 1'b1);
    check("empty_digest", bus.digest, EMPTY_DIG);

    send_block(TWO_BLK1, 1'b1);
    // second block offered in the digest_valid cycle: accepted with no bubble
    send_block(TWO_BLK2, 1'b0);
    check("two_digest", bus.digest, TWO_DIG);

    // abort at round 30; H currently holds TWO_DIG, so reset must restore the IV
    bus.blk_data  = ABC_BLK;
    bus.first_blk = 1'b1;
    bus.blk_valid = 1'b1;
    @(posedge clk); #1;
    bus.blk_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("k_addr_r30", 256'(bus.k_addr), 256'd30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 256'(bus.blk_ready), 256'd1);
    check("abort_busy", 256'(bus.busy), 256'd0);
    check("abort_kaddr", 256'(bus.k_addr), 256'd0);
    check("abort_digest", bus.digest, IV_DIG);
    dv_seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.digest_valid) dv_seen++;
      @(posedge clk); #1;
    end
    check("abort_no_dv", 256'(dv_seen), 256'd0);

    send_block(ABC_BLK, 1'b0);
    check("abc_after_rst", bus.digest, ABC_DIG);

`ifdef SHA224_EN
    bus.mode224 = 1'b1;
    send_block(ABC_BLK, 1'b1);
    bus.mode224 = 1'b0;
    check("sha224_digest", bus.digest,
          {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
